// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with 2-bit saturating direction counters
// for the RV32I core. The fetch stage looks up pc_i combinationally against
// the registered table. The execute stage trains the table with each resolved
// branch. A saturating 16-bit counter tracks mispredictions for performance
// debug.
//
// Parameters:
//   IDX_BITS  log2 of the number of entries
//   TAG_BITS  stored tag width (IDX_BITS+TAG_BITS+2 <= 32)
//
// Ports:
//   clk               clock, rising edge
//   rst_n             asynchronous active-low reset
//   flush_i           synchronous invalidate of all entries
//   pc_i              fetch PC to predict
//   pred_hit_o        valid entry with matching tag for pc_i
//   pred_taken_o      predicted taken
//   pred_target_o     predicted next PC
//   upd_en_i          a resolved branch is present this cycle
//   upd_pc_i          PC of the resolved branch
//   upd_taken_i       resolved outcome
//   upd_target_i      resolved branch target
//   upd_pred_taken_i  prediction made earlier for this branch
//   mispredict_o      resolved outcome differs from the earlier prediction
//   mispredict_cnt_o  saturating misprediction counter
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  output logic        pred_hit_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  output logic        mispredict_o,
  output logic [15:0] mispredict_cnt_o
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  // Table storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [15:0]         cnt_q;

  // Saturating arithmetic helpers
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  function automatic logic [15:0] cnt_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? 16'hFFFF : c + 16'd1;
  endfunction

  // Address decode for both ports; pc[1:0] and the bits above the tag do
  // not participate in indexing or matching.
  logic [IDX_BITS-1:0] rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                unused_pc_bits;

  assign rd_idx         = pc_i[IDX_BITS+1:2];
  assign rd_tag         = pc_i[TAG_HI:TAG_LO];
  assign upd_idx        = upd_pc_i[IDX_BITS+1:2];
  assign upd_tag        = upd_pc_i[TAG_HI:TAG_LO];
  assign unused_pc_bits = ^{pc_i, upd_pc_i};

  // Lookup: reads the registered table, so a same-cycle update to the same
  // entry is only seen on the following cycle.
  logic rd_hit;
  logic rd_taken;

  assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken      = rd_hit && ctr_q[rd_idx][1];
  assign pred_hit_o    = rd_hit;
  assign pred_taken_o  = rd_taken;
  assign pred_target_o = rd_taken ? target_q[rd_idx] : (pc_i + 32'd4);

  // Misprediction detect
  assign mispredict_o     = upd_en_i && (upd_taken_i != upd_pred_taken_i);
  assign mispredict_cnt_o = cnt_q;

  logic upd_hit;
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Table update and counter. Flush only clears valid bits and takes
  // priority over any training that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      cnt_q <= '0;
    end else begin
      if (mispredict_o) begin
        cnt_q <= cnt_inc(cnt_q);
      end
      if (flush_i) begin
        valid_q <= '0;
      end else if (upd_en_i) begin
        if (upd_hit) begin
          if (upd_taken_i) begin
            ctr_q[upd_idx]    <= ctr_inc(ctr_q[upd_idx]);
            target_q[upd_idx] <= upd_target_i;
          end else begin
            ctr_q[upd_idx] <= ctr_dec(ctr_q[upd_idx]);
          end
        end else if (upd_taken_i) begin
          // Allocate over whatever occupies the slot, weakly taken.
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target_i;
          ctr_q[upd_idx]    <= 2'b10;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic [31:0] pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_en_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_pred_taken_i;
  logic        mispredict_o;
  logic [15:0] mispredict_cnt_o;

  int tests;
  int fails;
  logic [15:0] exp_cnt;

  branch_predictor #(.IDX_BITS(4), .TAG_BITS(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush_i),
    .pc_i             (pc_i),
    .pred_hit_o       (pred_hit_o),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .upd_en_i         (upd_en_i),
    .upd_pc_i         (upd_pc_i),
    .upd_taken_i      (upd_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_pred_taken_i (upd_pred_taken_i),
    .mispredict_o     (mispredict_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle update; checks mispredict_o while the update is presented.
  task automatic do_upd(input logic [31:0] pc, input logic t,
                        input logic [31:0] tgt, input logic p);
    @(negedge clk);
    upd_en_i = 1'b1; upd_pc_i = pc; upd_taken_i = t;
    upd_target_i = tgt; upd_pred_taken_i = p;
    #1;
    tests++;
    if (mispredict_o !== (t != p)) begin
      fails++;
      $display("FAIL upd_mispredict pc=%h got %b want %b", pc, mispredict_o, (t != p));
    end
    @(posedge clk);
    #1 upd_en_i = 1'b0;
    if (t != p && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic look(input logic [31:0] pc);
    @(negedge clk);
    pc_i = pc;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush_i = 1'b0; pc_i = 32'h100; upd_en_i = 1'b0;
    upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0; upd_pred_taken_i = 1'b0;
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (pred_hit_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h104
        || mispredict_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL reset got hit=%b taken=%b tgt=%h cnt=%h want 0 0 00000104 0000",
               pred_hit_o, pred_taken_o, pred_target_o, mispredict_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alloc;
    @(negedge clk);
    pc_i = 32'h100;
    upd_en_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1;
    upd_target_i = 32'h80; upd_pred_taken_i = 1'b0;
    #1;
    tests++;
    if (mispredict_o !== 1'b1 || pred_hit_o !== 1'b0) begin
      fails++;
      $display("FAIL alloc_during got mp=%b hit=%b want 1 0", mispredict_o, pred_hit_o);
    end
    @(posedge clk);
    #1 upd_en_i = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    look(32'h100);
    tests++;
    if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h80
        || mispredict_cnt_o !== 16'd1) begin
      fails++;
      $display("FAIL alloc_after got hit=%b taken=%b tgt=%h cnt=%h want 1 1 00000080 0001",
               pred_hit_o, pred_taken_o, pred_target_o, mispredict_cnt_o);
    end
  endtask

  task automatic test_counter;
    do_upd(32'h100, 1'b0, 32'h0, 1'b0);
    do_upd(32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h100);
    tests++;
    if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin
      fails++;
      $display("FAIL ctr_00 got hit=%b taken=%b tgt=%h want 1 0 00000104",
               pred_hit_o, pred_taken_o, pred_target_o);
    end
    do_upd(32'h100, 1'b1, 32'h80, 1'b0);
    look(32'h100);
    tests++;
    if (pred_taken_o !== 1'b0) begin
      fails++;
      $display("FAIL ctr_01 got taken=%b want 0", pred_taken_o);
    end
    do_upd(32'h100, 1'b1, 32'h80, 1'b0);
    do_upd(32'h100, 1'b1, 32'h80, 1'b1);
    look(32'h100);
    tests++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h80) begin
      fails++;
      $display("FAIL ctr_11 got taken=%b tgt=%h want 1 00000080", pred_taken_o, pred_target_o);
    end
    // Fourth taken must hold 11 and refresh the target; one not-taken then
    // leaves it at 10 (still taken).
    do_upd(32'h100, 1'b1, 32'h90, 1'b1);
    look(32'h100);
    tests++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h90) begin
      fails++;
      $display("FAIL ctr_sat got taken=%b tgt=%h want 1 00000090", pred_taken_o, pred_target_o);
    end
    do_upd(32'h100, 1'b0, 32'h0, 1'b1);
    look(32'h100);
    tests++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h90
        || mispredict_cnt_o !== exp_cnt) begin
      fails++;
      $display("FAIL ctr_dec got taken=%b tgt=%h cnt=%h want 1 00000090 %h",
               pred_taken_o, pred_target_o, mispredict_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_alias;
    do_upd(32'h140, 1'b1, 32'h200, 1'b1);
    look(32'h100);
    tests++;
    if (pred_hit_o !== 1'b0 || pred_target_o !== 32'h104) begin
      fails++;
      $display("FAIL alias_old got hit=%b tgt=%h want 0 00000104", pred_hit_o, pred_target_o);
    end
    look(32'h140);
    tests++;
    if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b1 || pred_target_o !== 32'h200) begin
      fails++;
      $display("FAIL alias_new got hit=%b taken=%b tgt=%h want 1 1 00000200",
               pred_hit_o, pred_taken_o, pred_target_o);
    end
    // Miss with not-taken leaves the occupant alone.
    do_upd(32'h100, 1'b0, 32'h0, 1'b0);
    look(32'h140);
    tests++;
    if (pred_hit_o !== 1'b1 || pred_target_o !== 32'h200) begin
      fails++;
      $display("FAIL miss_nt got hit=%b tgt=%h want 1 00000200", pred_hit_o, pred_target_o);
    end
  endtask

  task automatic test_same_cycle;
    do_upd(32'h100, 1'b1, 32'h80, 1'b1);   // allocate, ctr 10
    do_upd(32'h100, 1'b0, 32'h0, 1'b0);    // ctr 01
    @(negedge clk);
    pc_i = 32'h100;
    upd_en_i = 1'b1; upd_pc_i = 32'h100; upd_taken_i = 1'b1;
    upd_target_i = 32'h84; upd_pred_taken_i = 1'b0;
    #1;
    tests++;
    if (pred_hit_o !== 1'b1 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h104) begin
      fails++;
      $display("FAIL same_cycle_pre got hit=%b taken=%b tgt=%h want 1 0 00000104",
               pred_hit_o, pred_taken_o, pred_target_o);
    end
    @(posedge clk);
    #1 upd_en_i = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    look(32'h100);
    tests++;
    if (pred_taken_o !== 1'b1 || pred_target_o !== 32'h84) begin
      fails++;
      $display("FAIL same_cycle_post got taken=%b tgt=%h want 1 00000084",
               pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_flush;
    @(negedge clk);
    flush_i = 1'b1;
    upd_en_i = 1'b1; upd_pc_i = 32'h208; upd_taken_i = 1'b1;
    upd_target_i = 32'h400; upd_pred_taken_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0; upd_en_i = 1'b0;
    look(32'h100);
    tests++;
    if (pred_hit_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_100 got hit=%b want 0", pred_hit_o);
    end
    look(32'h208);
    tests++;
    if (pred_hit_o !== 1'b0 || pred_target_o !== 32'h20C) begin
      fails++;
      $display("FAIL flush_208 got hit=%b tgt=%h want 0 0000020c", pred_hit_o, pred_target_o);
    end
    look(32'h140);
    tests++;
    if (pred_hit_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_140 got hit=%b want 0", pred_hit_o);
    end
    look(32'hFFFF_FFFC);
    tests++;
    if (pred_target_o !== 32'h0) begin
      fails++;
      $display("FAIL pc_wrap got tgt=%h want 00000000", pred_target_o);
    end
    tests++;
    if (mispredict_cnt_o !== exp_cnt) begin
      fails++;
      $display("FAIL flush_cnt got %h want %h", mispredict_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_saturate;
    @(negedge clk);
    upd_en_i = 1'b1; upd_pc_i = 32'h300; upd_taken_i = 1'b0;
    upd_target_i = 32'h0; upd_pred_taken_i = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    tests++;
    if (mispredict_cnt_o !== 16'hFFFF || mispredict_o !== 1'b1) begin
      fails++;
      $display("FAIL cnt_sat got cnt=%h mp=%b want ffff 1", mispredict_cnt_o, mispredict_o);
    end
    upd_en_i = 1'b0;
    exp_cnt = 16'hFFFF;
    look(32'h300);
    tests++;
    if (pred_hit_o !== 1'b0) begin
      fails++;
      $display("FAIL sat_no_alloc got hit=%b want 0", pred_hit_o);
    end
  endtask

  task automatic test_async_reset;
    do_upd(32'h100, 1'b1, 32'h80, 1'b0);
    look(32'h100);
    tests++;
    if (pred_hit_o !== 1'b1 || mispredict_cnt_o !== 16'hFFFF) begin
      fails++;
      $display("FAIL pre_reset got hit=%b cnt=%h want 1 ffff", pred_hit_o, mispredict_cnt_o);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (pred_hit_o !== 1'b0 || pred_taken_o !== 1'b0 || pred_target_o !== 32'h104
        || mispredict_cnt_o !== 16'd0) begin
      fails++;
      $display("FAIL async_reset got hit=%b taken=%b tgt=%h cnt=%h want 0 0 00000104 0000",
               pred_hit_o, pred_taken_o, pred_target_o, mispredict_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_same_cycle();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
